// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit for the EX stage: holds HI/LO, one shift step per cycle.
// Define MDU_DIV_EN to build the DIV/DIVU restoring divider; otherwise codes 3/4 act as NOP.
module mdu_iter #(
  parameter int IO_BUS_WIDTH = 32,
  parameter int OP_BUS_WIDTH = 3
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_flush,
  input  logic [OP_BUS_WIDTH-1:0] i_op,
  input  logic [IO_BUS_WIDTH-1:0] i_data_a,
  input  logic [IO_BUS_WIDTH-1:0] i_data_b,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [IO_BUS_WIDTH-1:0] o_hi,
  output logic [IO_BUS_WIDTH-1:0] o_lo
);
  localparam int N  = IO_BUS_WIDTH;
  localparam int CW = $clog2(N) + 1;

  localparam logic [OP_BUS_WIDTH-1:0] OP_MULT  = OP_BUS_WIDTH'(1);
  localparam logic [OP_BUS_WIDTH-1:0] OP_MULTU = OP_BUS_WIDTH'(2);
  localparam logic [OP_BUS_WIDTH-1:0] OP_DIV   = OP_BUS_WIDTH'(3);
  localparam logic [OP_BUS_WIDTH-1:0] OP_MTHI  = OP_BUS_WIDTH'(5);
  localparam logic [OP_BUS_WIDTH-1:0] OP_MTLO  = OP_BUS_WIDTH'(6);
`ifdef MDU_DIV_EN
  localparam logic [OP_BUS_WIDTH-1:0] OP_DIVU  = OP_BUS_WIDTH'(4);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   acc_q, acc_d;    // product, or {remainder, quotient} while dividing
  logic [N-1:0]     opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic             neg_lo_q, neg_lo_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic             done_q, done_d;
`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div0_q, div0_d;
`endif

  // Request decode and operand magnitudes
  logic         is_signed, is_mul, is_div, idle_req, accept;
  logic         a_neg, b_neg;
  logic [N-1:0] a_mag, b_mag;

  // NOTE: every always_comb output is given a default first, so no latch is inferred.
  always_comb begin
    is_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    is_mul    = (i_op == OP_MULT) || (i_op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div    = (i_op == OP_DIV) || (i_op == OP_DIVU);
`else
    is_div    = 1'b0;
`endif
    idle_req  = i_start && !i_flush && (state_q == S_IDLE);
    accept    = idle_req && (is_mul || is_div);
    a_neg     = is_signed && i_data_a[N-1];
    b_neg     = is_signed && i_data_b[N-1];
    a_mag     = a_neg ? -i_data_a : i_data_a;
    b_mag     = b_neg ? -i_data_b : i_data_b;
  end

  // One shift-add multiply step: multiplier bits are consumed from acc_q[0]
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[N-1:1]};

`ifdef MDU_DIV_EN
  // One restoring divide step: quotient bits enter at acc_q[0]
  logic [N:0]     div_shift;
  logic [N-1:0]   div_diff;
  logic           div_ge;
  logic [2*N-1:0] div_next;
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[N-1:0] - opnd_q;
  assign div_next  = {(div_ge ? div_diff : div_shift[N-1:0]), acc_q[N-2:0], div_ge};
`endif

  // State register
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN: begin
        if (i_flush)                  state_d = S_IDLE;
        else if (cnt_q == CW'(N - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_done = done_q;
    o_hi   = hi_q;
    o_lo   = lo_q;
  end

  // Datapath next-state
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == S_FIX) && !i_flush;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d    = '0;
          neg_lo_d = a_neg ^ b_neg;
          acc_d    = {{N{1'b0}}, (is_div ? a_mag : b_mag)};
          opnd_d   = is_div ? b_mag : a_mag;
`ifdef MDU_DIV_EN
          is_div_d = is_div;
          neg_hi_d = a_neg;
          div0_d   = (i_data_b == '0);
`endif
        end else if (idle_req && (i_op == OP_MTHI)) begin
          hi_d = i_data_a;
        end else if (idle_req && (i_op == OP_MTLO)) begin
          lo_d = i_data_a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
      end
      S_FIX: begin
        if (!i_flush) begin
`ifdef MDU_DIV_EN
          if (is_div_q) begin
            // Divide by zero yields all-ones quotient; remainder already equals the dividend.
            lo_d = div0_q ? '1 : (neg_lo_q ? -acc_q[N-1:0] : acc_q[N-1:0]);
            hi_d = neg_hi_q ? -acc_q[2*N-1:N] : acc_q[2*N-1:N];
          end else begin
            {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
          end
`else
          {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
`endif
        end
      end
      default: ;
    endcase
  end

  // NOTE: only architectural HI/LO and o_done need reset; datapath regs are loaded before use.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge i_clk) begin
    cnt_q    <= cnt_d;
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    neg_lo_q <= neg_lo_d;
`ifdef MDU_DIV_EN
    is_div_q <= is_div_d;
    neg_hi_q <= neg_hi_d;
    div0_q   <= div0_d;
`endif
  end

endmodule
